oam_dma_ctrl: RTL and testbench

Sprite-DMA controller and PPU-port arbiter between `cpu_toplevel` and `ppu_toplevel`. A CPU write to $4014 halts the CPU through `rdy`. The block then copies 256 bytes from CPU page $XX00–$XXFF into PPU OAMDATA (register 4) through the PPU register port. When idle, the CPU's own PPU register accesses pass straight through to the PPU.

---
 rtl/oam_dma_ctrl.sv | 138 +++++++++++++
 tb/tb_oam_dma_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite-DMA engine and PPU register-port arbiter.
// A CPU write to DMA_REG_ADDR halts the CPU and copies one 256-byte page
// into OAMDATA. Every read is placed on an even cycle. Outside DMA, the
// CPU's own PPU register accesses pass straight through.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [2:0]  OAMDATA_IDX  = 3'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_ppu_cs,
  input  logic [2:0]  cpu_ppu_addr,
  input  logic        cpu_ppu_we,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  input  logic [7:0]  dma_rd_data,
  output logic        ppu_reg_cs,
  output logic [2:0]  ppu_reg_addr,
  output logic        vram_WE,
  output logic [7:0]  vram_data_in,
  output logic        rdy,
  output logic        dma_active,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        cycle_odd;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic        trigger;

  assign trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

  // Free-running cycle parity used to keep reads on even cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cycle_odd <= 1'b0;
    else          cycle_odd <= ~cycle_odd;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Source page is captured only on an accepted trigger; idx steps once per OAM write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      page <= 8'h00;
      idx  <= 8'h00;
    end else if (state == S_IDLE && trigger) begin
      page <= cpu_wdata;
      idx  <= 8'h00;
    end else if (state == S_WRITE) begin
      idx  <= idx + 8'd1;
    end
  end

  // Next-state logic and port arbitration; idle defaults are CPU pass-through
  always_comb begin
    state_next   = state;
    dma_addr     = 16'h0000;
    dma_rd       = 1'b0;
    ppu_reg_cs   = cpu_ppu_cs;
    ppu_reg_addr = cpu_ppu_addr;
    vram_WE      = cpu_ppu_we;
    vram_data_in = cpu_wdata;
    rdy          = 1'b1;
    dma_active   = 1'b0;
    dma_done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (trigger) state_next = S_HALT;
      end
      S_HALT: begin
        rdy          = 1'b0;
        dma_active   = 1'b1;
        ppu_reg_cs   = 1'b0;
        ppu_reg_addr = OAMDATA_IDX;
        vram_WE      = 1'b0;
        vram_data_in = 8'h00;
        // An odd HALT means the next cycle is even and can read at once
        state_next   = cycle_odd ? S_READ : S_ALIGN;
      end
      S_ALIGN: begin
        rdy          = 1'b0;
        dma_active   = 1'b1;
        ppu_reg_cs   = 1'b0;
        ppu_reg_addr = OAMDATA_IDX;
        vram_WE      = 1'b0;
        vram_data_in = 8'h00;
        state_next   = S_READ;
      end
      S_READ: begin
        rdy          = 1'b0;
        dma_active   = 1'b1;
        dma_addr     = {page, idx};
        dma_rd       = 1'b1;
        ppu_reg_cs   = 1'b0;
        ppu_reg_addr = OAMDATA_IDX;
        vram_WE      = 1'b0;
        vram_data_in = 8'h00;
        state_next   = S_WRITE;
      end
      S_WRITE: begin
        rdy          = 1'b0;
        dma_active   = 1'b1;
        ppu_reg_cs   = 1'b1;
        ppu_reg_addr = OAMDATA_IDX;
        vram_WE      = 1'b1;
        vram_data_in = dma_rd_data;
        state_next   = (idx == 8'hFF) ? S_DONE : S_READ;
      end
      S_DONE: begin
        // CPU resumes here; a trigger in this cycle is deliberately dropped
        dma_done     = 1'b1;
        state_next   = S_IDLE;
      end
      default: begin
        state_next   = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: scoreboard bench for the sprite-DMA controller.
// Stimulus pushes expected read addresses, OAM bytes and halt lengths;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_we = 1'b0;
  logic        cpu_ppu_cs = 1'b0;
  logic [2:0]  cpu_ppu_addr = 3'd0;
  logic        cpu_ppu_we = 1'b0;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic [7:0]  dma_rd_data = 8'h00;
  logic        ppu_reg_cs;
  logic [2:0]  ppu_reg_addr;
  logic        vram_WE;
  logic [7:0]  vram_data_in;
  logic        rdy;
  logic        dma_active;
  logic        dma_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_addr_q[$];
  logic [7:0]  exp_data_q[$];
  int          exp_len_q[$];
  logic        tb_par;
  int          low_run = 0;

  oam_dma_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_we       (cpu_we),
    .cpu_ppu_cs   (cpu_ppu_cs),
    .cpu_ppu_addr (cpu_ppu_addr),
    .cpu_ppu_we   (cpu_ppu_we),
    .dma_addr     (dma_addr),
    .dma_rd       (dma_rd),
    .dma_rd_data  (dma_rd_data),
    .ppu_reg_cs   (ppu_reg_cs),
    .ppu_reg_addr (ppu_reg_addr),
    .vram_WE      (vram_WE),
    .vram_data_in (vram_data_in),
    .rdy          (rdy),
    .dma_active   (dma_active),
    .dma_done     (dma_done)
  );

  always #5 clk = ~clk;

  // Reference cycle phase: 0 out of reset, toggles every clock
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_par <= 1'b0;
    else          tb_par <= ~tb_par;
  end

  // Memory model: one-cycle latency, data = addr[7:0] ^ A5
  always @(posedge clk) begin
    if (dma_rd) dma_rd_data <= dma_addr[7:0] ^ 8'hA5;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event with no expectation at %0t", name, $time);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset_n) begin
      if (dma_rd) begin
        chk("rd_even_cycle", {31'd0, tb_par}, 32'd0);
        if (exp_addr_q.size() == 0) fail_now("rd_unexpected");
        else chk("dma_addr", {16'd0, dma_addr}, {16'd0, exp_addr_q.pop_front()});
      end
      if (dma_active) begin
        chk("ppu_cs_matches_we", {31'd0, ppu_reg_cs}, {31'd0, vram_WE});
        chk("rdy_low_while_active", {31'd0, rdy}, 32'd0);
        if (vram_WE) begin
          chk("oam_reg_addr", {29'd0, ppu_reg_addr}, 32'd4);
          if (exp_data_q.size() == 0) fail_now("oam_unexpected");
          else chk("oam_data", {24'd0, vram_data_in}, {24'd0, exp_data_q.pop_front()});
        end
      end
      if (!rdy) begin
        low_run++;
      end else begin
        if (dma_done) begin
          if (exp_len_q.size() == 0) fail_now("done_unexpected");
          else chk("rdy_low_cycles", low_run, exp_len_q.pop_front());
        end
        low_run = 0;
      end
    end else begin
      low_run = 0;
    end
  end

  // Issue a $4014 write in a cycle whose phase equals want_par
  task automatic start_dma(input logic [7:0] pg, input logic want_par);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (tb_par == want_par) break;
    end
    for (int n = 0; n < 256; n++) begin
      exp_addr_q.push_back({pg, n[7:0]});
      exp_data_q.push_back(n[7:0] ^ 8'hA5);
    end
    exp_len_q.push_back(want_par ? 514 : 513);
    cpu_we    = 1'b1;
    cpu_addr  = 16'h4014;
    cpu_wdata = pg;
    @(posedge clk); #1;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
  endtask

  // Returns inside the DONE cycle (1 ns after its rising edge)
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk); #1;
      if (dma_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("done_timeout");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy"},        {31'd0, rdy},        32'd1);
    chk({tag, "_dma_active"}, {31'd0, dma_active}, 32'd0);
    chk({tag, "_dma_done"},   {31'd0, dma_done},   32'd0);
    chk({tag, "_dma_rd"},     {31'd0, dma_rd},     32'd0);
    chk({tag, "_dma_addr"},   {16'd0, dma_addr},   32'd0);
  endtask

  task automatic chk_pass(input string tag, input logic cs, input logic [2:0] a,
                          input logic we, input logic [7:0] d);
    cpu_ppu_cs   = cs;
    cpu_ppu_addr = a;
    cpu_ppu_we   = we;
    cpu_wdata    = d;
    #1;
    chk({tag, "_cs"},   {31'd0, ppu_reg_cs},   {31'd0, cs});
    chk({tag, "_addr"}, {29'd0, ppu_reg_addr}, {29'd0, a});
    chk({tag, "_we"},   {31'd0, vram_WE},      {31'd0, we});
    chk({tag, "_data"}, {24'd0, vram_data_in}, {24'd0, d});
  endtask

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    #2 reset_n = 1'b1;

    // Idle pass-through, two patterns
    @(posedge clk); #1;
    chk_pass("pass1", 1'b1, 3'd6, 1'b1, 8'h3F);
    chk("pass1_rdy", {31'd0, rdy}, 32'd1);
    chk("pass1_active", {31'd0, dma_active}, 32'd0);
    chk_pass("pass2", 1'b1, 3'd2, 1'b0, 8'h80);
    chk_pass("pass3", 1'b0, 3'd0, 1'b0, 8'h00);

    // Even-cycle trigger, page $02
    start_dma(8'h02, 1'b0);
    wait_done();
    // A trigger during DONE must be dropped
    cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h55;
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    chk("done_trig_active", {31'd0, dma_active}, 32'd0);
    @(posedge clk); #1;
    chk("done_trig_active2", {31'd0, dma_active}, 32'd0);
    chk("done_trig_rdy", {31'd0, rdy}, 32'd1);

    // Odd-cycle trigger, page $FF
    start_dma(8'hFF, 1'b1);
    wait_done();

    // Re-trigger and CPU PPU strobes during DMA are ignored
    start_dma(8'h13, 1'b0);
    cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h77;
    cpu_ppu_cs = 1'b1; cpu_ppu_addr = 3'd2; cpu_ppu_we = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    cpu_ppu_cs = 1'b0; cpu_ppu_addr = 3'd0; cpu_ppu_we = 1'b0;
    wait_done();

    // Reset while reading byte 100, then a fresh transfer
    start_dma(8'h40, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (dma_rd && dma_addr == 16'h4064) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now("byte100_timeout");
    #2;
    reset_n = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_len_q.delete();
    #1;
    chk_reset_outputs("midreset");
    chk_pass("midreset_pass", 1'b1, 3'd5, 1'b1, 8'hC3);
    chk_pass("midreset_clr", 1'b0, 3'd0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    start_dma(8'h40, 1'b0);
    wait_done();

    repeat (4) @(posedge clk);
    #1;
    chk("addr_q_drained", exp_addr_q.size(), 32'd0);
    chk("data_q_drained", exp_data_q.size(), 32'd0);
    chk("len_q_drained",  exp_len_q.size(),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
